// File: rtl/trap_sequencer_if.sv
// Trap sequencer bus: trap request/handled handshake, CSR commit, flush and redirect signals.
// master = the sequencer itself, slave = the surrounding core (priority stage, CSR file, fetch).
interface trap_sequencer_if;
  logic        i_err_pending;
  logic [31:0] i_err_cause;
  logic        o_err_handled;
  logic [31:0] i_epc;
  logic [31:0] i_tval;
  logic [31:0] i_mtvec;
  logic        i_mret;
  logic [31:0] i_mepc;
  logic        o_flush;
  logic        i_flush_done;
  logic        o_csr_we;
  logic [31:0] o_mcause;
  logic [31:0] o_mepc;
  logic [31:0] o_mtval;
  logic        o_mret_done;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_busy;
  logic        o_flush_timeout;

  modport master (
    input  i_err_pending, i_err_cause, i_epc, i_tval, i_mtvec, i_mret, i_mepc, i_flush_done,
    output o_err_handled, o_flush, o_csr_we, o_mcause, o_mepc, o_mtval, o_mret_done,
           o_redirect, o_redirect_pc, o_busy, o_flush_timeout
  );

  modport slave (
    output i_err_pending, i_err_cause, i_epc, i_tval, i_mtvec, i_mret, i_mepc, i_flush_done,
    input  o_err_handled, o_flush, o_csr_we, o_mcause, o_mepc, o_mtval, o_mret_done,
           o_redirect, o_redirect_pc, o_busy, o_flush_timeout
  );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: flush -> CSR commit -> trap-vector redirect, plus mret return.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets (mtvec mode 2'b01).
module trap_sequencer #(
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  trap_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FLUSH    = 3'd1,
    S_COMMIT   = 3'd2,
    S_REDIRECT = 3'd3,
    S_RET      = 3'd4
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(FLUSH_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] ret_pc_q, ret_pc_d;
  logic [31:0] trap_pc;

`ifdef TRAP_VECTORED_EN
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic        is_irq,
                                              input logic [29:0] code);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && is_irq)
      return base + {code, 2'b00};
    return base;
  endfunction

  assign trap_pc = trap_target(bus.i_mtvec, cause_q[31], cause_q[29:0]);
`else
  function automatic logic [31:0] trap_target(input logic [29:0] mtvec_base);
    return {mtvec_base, 2'b00};
  endfunction

  assign trap_pc = trap_target(bus.i_mtvec[31:2]);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cause_q  <= '0;
      epc_q    <= '0;
      tval_q   <= '0;
      ret_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      tval_q   <= tval_d;
      ret_pc_q <= ret_pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    tval_d   = tval_q;
    ret_pc_d = ret_pc_q;
    unique case (state_q)
      S_IDLE: begin
        // A trap beats a coincident mret: the flush would kill the mret anyway.
        if (bus.i_err_pending) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
          cause_d = bus.i_err_cause;
          epc_d   = bus.i_epc;
          tval_d  = bus.i_tval;
        end else if (bus.i_mret) begin
          state_d  = S_RET;
          ret_pc_d = {bus.i_mepc[31:2], 2'b00};
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.i_flush_done || cnt_q == CNT_LAST)
          state_d = S_COMMIT;
      end
      S_COMMIT:   state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      S_RET:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs decode registered state only; i_mtvec -> o_redirect_pc is the one combinational path.
  always_comb begin
    bus.o_flush         = 1'b0;
    bus.o_flush_timeout = 1'b0;
    bus.o_csr_we        = 1'b0;
    bus.o_err_handled   = 1'b0;
    bus.o_redirect      = 1'b0;
    bus.o_redirect_pc   = '0;
    bus.o_mret_done     = 1'b0;
    bus.o_busy          = (state_q != S_IDLE);
    bus.o_mcause        = cause_q;
    bus.o_mepc          = epc_q;
    bus.o_mtval         = tval_q;
    unique case (state_q)
      S_FLUSH: begin
        bus.o_flush         = 1'b1;
        bus.o_flush_timeout = (cnt_q == CNT_LAST);
      end
      S_COMMIT: begin
        bus.o_csr_we      = 1'b1;
        bus.o_err_handled = 1'b1;
      end
      S_REDIRECT: begin
        bus.o_redirect    = 1'b1;
        bus.o_redirect_pc = trap_pc;
      end
      S_RET: begin
        bus.o_redirect    = 1'b1;
        bus.o_redirect_pc = ret_pc_q;
        bus.o_mret_done   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: scoreboard of expected CSR commits and redirects.
module tb_trap_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    bit          is_csr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    bit          mret;
  } exp_t;

  exp_t sb[$];

  trap_sequencer_if tif ();

  trap_sequencer #(.FLUSH_TIMEOUT(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (tif.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_csr(input logic [31:0] cause, input logic [31:0] epc, input logic [31:0] tval);
    exp_t e;
    e.is_csr = 1'b1; e.a = cause; e.b = epc; e.c = tval; e.mret = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_red(input logic [31:0] pc, input bit mret);
    exp_t e;
    e.is_csr = 1'b0; e.a = pc; e.b = '0; e.c = '0; e.mret = mret;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (tif.o_busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(tif.o_busy), 32'd0);
  endtask

  // Scoreboard consumer: every CSR write or redirect must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (tif.o_csr_we || tif.o_redirect)) begin
      exp_t e;
      chk("sb_nonempty", 32'(sb.size() == 0), 32'd0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (tif.o_csr_we) begin
          chk("sb_kind_csr", 32'(e.is_csr), 32'd1);
          chk("mcause", tif.o_mcause, e.a);
          chk("mepc", tif.o_mepc, e.b);
          chk("mtval", tif.o_mtval, e.c);
          chk("err_handled_with_we", 32'(tif.o_err_handled), 32'd1);
          chk("no_redirect_in_commit", 32'(tif.o_redirect), 32'd0);
        end else begin
          chk("sb_kind_redirect", 32'(e.is_csr), 32'd0);
          chk("redirect_pc", tif.o_redirect_pc, e.a);
          chk("mret_done", 32'(tif.o_mret_done), 32'(e.mret));
        end
      end
    end
  end

  initial begin
    int n, tpos, ntime, nm, nc, nr;
    logic [31:0] vec_pc;

    tif.i_err_pending = 1'b0; tif.i_err_cause = '0; tif.i_epc = '0; tif.i_tval = '0;
    tif.i_mtvec = '0; tif.i_mret = 1'b0; tif.i_mepc = '0; tif.i_flush_done = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(tif.o_busy), 32'd0);
    chk("rst_flush", 32'(tif.o_flush), 32'd0);
    chk("rst_csr_we", 32'(tif.o_csr_we), 32'd0);
    chk("rst_redirect", 32'(tif.o_redirect), 32'd0);
    chk("rst_mcause", tif.o_mcause, 32'd0);

    // Basic trap, flush done in first FLUSH cycle
    tif.i_err_pending = 1'b1; tif.i_err_cause = 32'd2; tif.i_epc = 32'h100;
    tif.i_tval = 32'hDEAD; tif.i_mtvec = 32'h8000_0001; tif.i_flush_done = 1'b1;
    push_csr(32'd2, 32'h100, 32'hDEAD);
    push_red(32'h8000_0000, 1'b0);
    step();
    tif.i_err_pending = 1'b0;
    @(negedge clk);
    chk("c1_flush", 32'(tif.o_flush), 32'd1);
    chk("c1_busy", 32'(tif.o_busy), 32'd1);
    chk("c1_csr_we", 32'(tif.o_csr_we), 32'd0);
    step(); @(negedge clk);
    chk("c2_csr_we", 32'(tif.o_csr_we), 32'd1);
    chk("c2_err_handled", 32'(tif.o_err_handled), 32'd1);
    chk("c2_flush", 32'(tif.o_flush), 32'd0);
    step(); @(negedge clk);
    chk("c3_redirect", 32'(tif.o_redirect), 32'd1);
    chk("c3_csr_we", 32'(tif.o_csr_we), 32'd0);
    step(); @(negedge clk);
    chk("c4_idle", 32'(tif.o_busy), 32'd0);
    chk("c4_redirect", 32'(tif.o_redirect), 32'd0);

    // Flush timeout: done held low
    tif.i_flush_done = 1'b0;
    tif.i_err_pending = 1'b1; tif.i_err_cause = 32'd5; tif.i_epc = 32'h200;
    tif.i_tval = 32'h44; tif.i_mtvec = 32'h4000;
    push_csr(32'd5, 32'h200, 32'h44);
    push_red(32'h4000, 1'b0);
    step();
    tif.i_err_pending = 1'b0;
    n = 0; tpos = 0; ntime = 0;
    repeat (40) begin
      @(negedge clk);
      if (tif.o_flush) begin
        n++;
        if (tif.o_flush_timeout) begin
          ntime++;
          tpos = n;
        end
      end else if (n > 0) begin
        break;
      end
    end
    chk("to_commit_follows", 32'(tif.o_csr_we), 32'd1);
    chk("to_flush_cycles", 32'(n), 32'd16);
    chk("to_pulse_pos", 32'(tpos), 32'd16);
    chk("to_pulse_count", 32'(ntime), 32'd1);
    wait_idle("to_idle");

    // mret return
    tif.i_mepc = 32'h2003; tif.i_mret = 1'b1;
    push_red(32'h2000, 1'b1);
    step();
    tif.i_mret = 1'b0;
    @(negedge clk);
    chk("ret_redirect", 32'(tif.o_redirect), 32'd1);
    chk("ret_mret_done", 32'(tif.o_mret_done), 32'd1);
    chk("ret_no_csr_we", 32'(tif.o_csr_we), 32'd0);
    step(); @(negedge clk);
    chk("ret_idle", 32'(tif.o_busy), 32'd0);

    // Trap and mret together: trap wins
    tif.i_flush_done = 1'b1;
    tif.i_err_pending = 1'b1; tif.i_mret = 1'b1; tif.i_mepc = 32'h5000;
    tif.i_err_cause = 32'hB; tif.i_epc = 32'h400; tif.i_tval = 32'h0; tif.i_mtvec = 32'h3000;
    push_csr(32'hB, 32'h400, 32'h0);
    push_red(32'h3000, 1'b0);
    step();
    tif.i_err_pending = 1'b0; tif.i_mret = 1'b0;
    nm = 0; nc = 0;
    repeat (5) begin
      @(negedge clk);
      if (tif.o_mret_done) nm++;
      if (tif.o_csr_we) nc++;
    end
    chk("both_no_mret_done", 32'(nm), 32'd0);
    chk("both_one_csr_we", 32'(nc), 32'd1);

    // Interrupt cause with vectored mtvec
`ifdef TRAP_VECTORED_EN
    vec_pc = 32'h101C;
`else
    vec_pc = 32'h1000;
`endif
    tif.i_err_pending = 1'b1; tif.i_err_cause = 32'h8000_0007; tif.i_epc = 32'h600;
    tif.i_tval = 32'h0; tif.i_mtvec = 32'h1001;
    push_csr(32'h8000_0007, 32'h600, 32'h0);
    push_red(vec_pc, 1'b0);
    step();
    tif.i_err_pending = 1'b0;
    @(negedge clk);
    wait_idle("vec_idle");

    // Asynchronous reset during FLUSH aborts the sequence
    tif.i_flush_done = 1'b0;
    tif.i_err_pending = 1'b1; tif.i_err_cause = 32'h3; tif.i_epc = 32'h700; tif.i_tval = 32'h99;
    step();
    tif.i_err_pending = 1'b0;
    @(negedge clk);
    chk("ar_in_flush", 32'(tif.o_flush), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_flush", 32'(tif.o_flush), 32'd0);
    chk("ar_busy", 32'(tif.o_busy), 32'd0);
    chk("ar_mcause", tif.o_mcause, 32'd0);
    chk("ar_mepc", tif.o_mepc, 32'd0);
    chk("ar_redirect_pc", tif.o_redirect_pc, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    nc = 0; nr = 0;
    repeat (10) begin
      @(negedge clk);
      if (tif.o_csr_we) nc++;
      if (tif.o_redirect) nr++;
    end
    chk("ar_no_csr_we", 32'(nc), 32'd0);
    chk("ar_no_redirect", 32'(nr), 32'd0);
    chk("ar_idle", 32'(tif.o_busy), 32'd0);

    // Back-to-back traps: pending still high in the first IDLE cycle
    tif.i_flush_done = 1'b1;
    tif.i_err_pending = 1'b1; tif.i_err_cause = 32'd4; tif.i_epc = 32'h800;
    tif.i_tval = 32'h11; tif.i_mtvec = 32'h6000;
    push_csr(32'd4, 32'h800, 32'h11);
    push_red(32'h6000, 1'b0);
    push_csr(32'd6, 32'h900, 32'h22);
    push_red(32'h6000, 1'b0);
    step();
    tif.i_err_cause = 32'd6; tif.i_epc = 32'h900; tif.i_tval = 32'h22;
    step(); step(); step();
    @(negedge clk);
    chk("b2b_idle_gap", 32'(tif.o_busy), 32'd0);
    step();
    tif.i_err_pending = 1'b0;
    @(negedge clk);
    chk("b2b_second_flush", 32'(tif.o_flush), 32'd1);
    wait_idle("b2b_idle");

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
